// File: rtl/muldiv_seq_if.sv
// Execute-stage handshake between the pipeline and the iterative RV32M multiply/divide sequencer.
// The master side is the pipeline/hazard logic; the slave side is muldiv_seq.
interface muldiv_seq_if #(parameter int DATA_WIDTH = 32);
  logic                  start_e;
  logic [2:0]            funct3_e;
  logic [DATA_WIDTH-1:0] src_a_e;
  logic [DATA_WIDTH-1:0] src_b_e;
  logic [4:0]            rd_e;
  logic                  flush_e;
  logic                  stall_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic [4:0]            rd_o;

  modport master (
    output start_e, funct3_e, src_a_e, src_b_e, rd_e, flush_e,
    input  stall_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_e, funct3_e, src_a_e, src_b_e, rd_e, flush_e,
    output stall_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: shift-add multiply / restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes once the remaining multiplier bits are zero.
module muldiv_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state;
  logic [2:0]           op;
  logic                 neg;
  logic [W-1:0]         bop;   // multiplicand or divisor magnitude
  logic [2*W-1:0]       acc;   // {product hi, multiplier/product lo} or {rem, quot}
  logic [CNT_WIDTH-1:0] cnt;

  logic         go, is_div, a_neg, b_neg, neg_start, div0, ovf, early, last;
  logic [W-1:0] a_mag, b_mag, special;
  logic [W:0]   sum, shl, diff;
  logic [2*W-1:0] mul_nxt, div_nxt, acc_fin;

  assign go     = bus.start_e & ~bus.flush_e;
  assign is_div = bus.funct3_e[2];

  // MULHSU treats only rs1 as signed; DIV/REM/MULH treat both as signed.
  assign a_neg = bus.src_a_e[W-1] & (bus.funct3_e == 3'd1 || bus.funct3_e == 3'd2 ||
                                     bus.funct3_e == 3'd4 || bus.funct3_e == 3'd6);
  assign b_neg = bus.src_b_e[W-1] & (bus.funct3_e == 3'd1 || bus.funct3_e == 3'd4 ||
                                     bus.funct3_e == 3'd6);
  assign a_mag = a_neg ? -bus.src_a_e : bus.src_a_e;
  assign b_mag = b_neg ? -bus.src_b_e : bus.src_b_e;
  assign neg_start = (bus.funct3_e == 3'd6) ? a_neg : (a_neg ^ b_neg);

  assign div0 = (bus.src_b_e == '0);
  assign ovf  = is_div & ~bus.funct3_e[0] & (bus.src_a_e == {1'b1, {(W-1){1'b0}}}) &
                (bus.src_b_e == '1);
  assign special = div0 ? (bus.funct3_e[1] ? bus.src_a_e : '1)
                        : (bus.funct3_e[1] ? '0 : {1'b1, {(W-1){1'b0}}});

  always_comb begin
    sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, bop} : '0);
    mul_nxt = {sum, acc[W-1:1]};
    shl     = {acc[2*W-1:W], acc[W-1]};
    diff    = shl - {1'b0, bop};
    div_nxt = diff[W] ? {shl[W-1:0], acc[W-2:0], 1'b0} : {diff[W-1:0], acc[W-2:0], 1'b1};
  end

`ifdef MULDIV_EARLY_OUT_EN
  // After this step the unconsumed multiplier bits sit in [cnt-2:0] of the low word.
  logic [W-1:0] rem_mask;
  assign rem_mask = (W'(1) << (cnt - 1'b1)) - W'(1);
  assign early    = (state == MUL) && ((mul_nxt[W-1:0] & rem_mask) == '0);
  assign acc_fin  = (state == MUL) ? (early ? (mul_nxt >> (cnt - 1'b1)) : mul_nxt) : div_nxt;
`else
  assign early   = 1'b0;
  assign acc_fin = (state == MUL) ? mul_nxt : div_nxt;
`endif

  assign last = (cnt == CNT_WIDTH'(1)) | early;

  function automatic logic [W-1:0] pick(input logic [2:0] f, input logic n,
                                        input logic [2*W-1:0] v);
    logic [2*W-1:0] p;
    logic [W-1:0]   q;
    p = n ? -v : v;
    q = f[1] ? v[2*W-1:W] : v[W-1:0];
    if (!f[2]) return (f == 3'd0) ? p[W-1:0] : p[2*W-1:W];
    return n ? -q : q;
  endfunction

  assign bus.stall_o = ((state == IDLE) & go) |
                       (((state == MUL) | (state == DIV)) & ~bus.flush_e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op           <= '0;
      neg          <= 1'b0;
      bop          <= '0;
      acc          <= '0;
      cnt          <= '0;
      bus.done_o   <= 1'b0;
      bus.result_o <= '0;
      bus.rd_o     <= '0;
    end else begin
      bus.done_o <= 1'b0;
      case (state)
        IDLE: if (go) begin
          op       <= bus.funct3_e;
          neg      <= neg_start;
          bus.rd_o <= bus.rd_e;
          cnt      <= CNT_WIDTH'(W);
          bop      <= is_div ? b_mag : a_mag;
          acc      <= {{W{1'b0}}, is_div ? a_mag : b_mag};
          if (is_div & (div0 | ovf)) begin
            bus.result_o <= special;
            bus.done_o   <= 1'b1;
            state        <= DONE;
          end else begin
            state <= is_div ? DIV : MUL;
          end
        end
        MUL, DIV: begin
          if (bus.flush_e) begin
            state <= IDLE;
          end else begin
            acc <= acc_fin;
            cnt <= cnt - 1'b1;
            if (last) begin
              bus.result_o <= pick(op, neg, acc_fin);
              bus.done_o   <= 1'b1;
              state        <= DONE;
            end
          end
        end
        // The instruction retires this cycle; a start seen here is that same instruction.
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq; expected values computed by hand.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_seq_if #(.DATA_WIDTH(32)) bus ();
  muldiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  // Expected multiply latency given the index of the top set bit of |multiplier|.
  function automatic int mlat(input int idx);
    return EARLY ? idx + 2 : 33;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res,
                        output logic [4:0] rdo, output int lat, output int nstall);
    @(posedge clk); #1;
    bus.start_e = 1'b1; bus.funct3_e = f; bus.src_a_e = a; bus.src_b_e = b; bus.rd_e = rd;
    lat = -1; nstall = 0; res = '0; rdo = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.stall_o) nstall++;
      if (bus.done_o) begin
        res = bus.result_o; rdo = bus.rd_o; lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.start_e = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_e = 0; bus.funct3_e = 0; bus.src_a_e = 0; bus.src_b_e = 0; bus.rd_e = 0;
    bus.flush_e = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) $display("FAIL rst_stall got %b exp 0", bus.stall_o); else passed++;
    checks++; if (bus.done_o !== 1'b0) $display("FAIL rst_done got %b exp 0", bus.done_o); else passed++;
    checks++; if (bus.result_o !== 32'd0) $display("FAIL rst_result got %h exp 0", bus.result_o); else passed++;
    checks++; if (bus.rd_o !== 5'd0) $display("FAIL rst_rd got %h exp 0", bus.rd_o); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] r; logic [4:0] d; int l, s;
    run_op(3'd0, 32'd7, 32'd6, 5'd5, r, d, l, s);
    checks++; if (r !== 32'd42) $display("FAIL mul_res got %h exp %h", r, 32'd42); else passed++;
    checks++; if (l !== mlat(2)) $display("FAIL mul_lat got %0d exp %0d", l, mlat(2)); else passed++;
    checks++; if (s !== mlat(2)) $display("FAIL mul_stall got %0d exp %0d", s, mlat(2)); else passed++;
    checks++; if (d !== 5'd5) $display("FAIL mul_rd got %0d exp 5", d); else passed++;
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b0) $display("FAIL mul_pulse got %b exp 0", bus.done_o); else passed++;
    checks++; if (bus.result_o !== 32'd42) $display("FAIL mul_hold got %h exp %h", bus.result_o, 32'd42); else passed++;
  endtask

  task automatic test_mulh();
    logic [31:0] r; logic [4:0] d; int l, s;
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, r, d, l, s);
    checks++; if (r !== 32'h0) $display("FAIL mulh_res got %h exp 0", r); else passed++;
    checks++; if (l !== mlat(0)) $display("FAIL mulh_lat got %0d exp %0d", l, mlat(0)); else passed++;
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, r, d, l, s);
    checks++; if (r !== 32'hFFFFFFFE) $display("FAIL mulhu_res got %h exp fffffffe", r); else passed++;
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 5'd3, r, d, l, s);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL mulhsu_res got %h exp ffffffff", r); else passed++;
    checks++; if (l !== mlat(1)) $display("FAIL mulhsu_lat got %0d exp %0d", l, mlat(1)); else passed++;
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, r, d, l, s);
    checks++; if (r !== 32'h1) $display("FAIL mul_lo_res got %h exp 1", r); else passed++;
  endtask

  task automatic test_div();
    logic [31:0] r; logic [4:0] d; int l, s;
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd6, r, d, l, s);
    checks++; if (r !== 32'hFFFFFFFD) $display("FAIL div_res got %h exp fffffffd", r); else passed++;
    checks++; if (l !== 33) $display("FAIL div_lat got %0d exp 33", l); else passed++;
    checks++; if (s !== 33) $display("FAIL div_stall got %0d exp 33", s); else passed++;
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd7, r, d, l, s);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL rem_res got %h exp ffffffff", r); else passed++;
    run_op(3'd5, 32'd100, 32'd7, 5'd8, r, d, l, s);
    checks++; if (r !== 32'd14) $display("FAIL divu_res got %h exp %h", r, 32'd14); else passed++;
    run_op(3'd7, 32'd100, 32'd7, 5'd8, r, d, l, s);
    checks++; if (r !== 32'd2) $display("FAIL remu_res got %h exp 2", r); else passed++;
  endtask

  task automatic test_special();
    logic [31:0] r; logic [4:0] d; int l, s;
    run_op(3'd5, 32'd5, 32'd0, 5'd10, r, d, l, s);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL divu0_res got %h exp ffffffff", r); else passed++;
    checks++; if (l !== 1) $display("FAIL divu0_lat got %0d exp 1", l); else passed++;
    checks++; if (d !== 5'd10) $display("FAIL divu0_rd got %0d exp 10", d); else passed++;
    run_op(3'd7, 32'd5, 32'd0, 5'd11, r, d, l, s);
    checks++; if (r !== 32'd5) $display("FAIL remu0_res got %h exp 5", r); else passed++;
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, r, d, l, s);
    checks++; if (r !== 32'h80000000) $display("FAIL divovf_res got %h exp 80000000", r); else passed++;
    checks++; if (l !== 1) $display("FAIL divovf_lat got %0d exp 1", l); else passed++;
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, r, d, l, s);
    checks++; if (r !== 32'h0) $display("FAIL removf_res got %h exp 0", r); else passed++;
  endtask

  task automatic test_flush();
    int s = 0, dn = 0;
    @(posedge clk); #1;
    bus.start_e = 1; bus.funct3_e = 3'd5; bus.src_a_e = 32'd100; bus.src_b_e = 32'd7; bus.rd_e = 5'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.stall_o) s++;
      if (bus.done_o) dn++;
      @(posedge clk); #1;
    end
    checks++; if (s !== 10) $display("FAIL flush_pre_stall got %0d exp 10", s); else passed++;
    bus.flush_e = 1'b1;
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) $display("FAIL flush_stall got %b exp 0", bus.stall_o); else passed++;
    // A divide-by-zero issued in cycle 11 only completes in cycle 12 if the block is back in IDLE.
    @(posedge clk); #1;
    bus.flush_e = 1'b0; bus.funct3_e = 3'd5; bus.src_a_e = 32'd9; bus.src_b_e = 32'd0; bus.rd_e = 5'd9;
    @(negedge clk);
    if (bus.done_o) dn++;
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b1) $display("FAIL flush_idle got %b exp 1", bus.done_o); else passed++;
    checks++; if (bus.result_o !== 32'hFFFFFFFF) $display("FAIL flush_next_res got %h exp ffffffff", bus.result_o); else passed++;
    @(posedge clk); #1;
    bus.start_e = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) dn++;
    end
    checks++; if (dn !== 0) $display("FAIL flush_done got %0d exp 0", dn); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [4:0] d; int l, s;
    @(posedge clk); #1;
    bus.start_e = 1; bus.funct3_e = 3'd0; bus.src_a_e = 32'd7; bus.src_b_e = 32'd6; bus.rd_e = 5'd21;
    repeat (5) @(posedge clk);
    #1;
    bus.start_e = 1'b0; rst_n = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0) $display("FAIL rmid_stall got %b exp 0", bus.stall_o); else passed++;
    checks++; if (bus.done_o !== 1'b0) $display("FAIL rmid_done got %b exp 0", bus.done_o); else passed++;
    checks++; if (bus.result_o !== 32'd0) $display("FAIL rmid_result got %h exp 0", bus.result_o); else passed++;
    checks++; if (bus.rd_o !== 5'd0) $display("FAIL rmid_rd got %0d exp 0", bus.rd_o); else passed++;
    #2 rst_n = 1'b1;
    run_op(3'd5, 32'd100, 32'd7, 5'd12, r, d, l, s);
    checks++; if (r !== 32'd14) $display("FAIL rmid_next_res got %h exp %h", r, 32'd14); else passed++;
    checks++; if (l !== 33) $display("FAIL rmid_next_lat got %0d exp 33", l); else passed++;
    checks++; if (d !== 5'd12) $display("FAIL rmid_next_rd got %0d exp 12", d); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic [4:0] d; int l, s;
    run_op(3'd5, 32'd1000, 32'd10, 5'd14, r, d, l, s);
    checks++; if (r !== 32'd100) $display("FAIL b2b_div_res got %h exp %h", r, 32'd100); else passed++;
    run_op(3'd0, 32'd12345, 32'd0, 5'd15, r, d, l, s);
    checks++; if (r !== 32'd0) $display("FAIL b2b_mul0_res got %h exp 0", r); else passed++;
    checks++; if (l !== (EARLY ? 2 : 33)) $display("FAIL b2b_mul0_lat got %0d exp %0d", l, EARLY ? 2 : 33); else passed++;
    checks++; if (d !== 5'd15) $display("FAIL b2b_rd got %0d exp 15", d); else passed++;
  endtask

  task automatic test_early_out();
    logic [31:0] r; logic [4:0] d; int l, s;
    run_op(3'd0, 32'd3, 32'd5, 5'd16, r, d, l, s);
    checks++; if (r !== 32'd15) $display("FAIL eo_res got %h exp %h", r, 32'd15); else passed++;
    checks++; if (l !== mlat(2)) $display("FAIL eo_lat got %0d exp %0d", l, mlat(2)); else passed++;
    run_op(3'd1, 32'hFFFFFFFD, 32'd4, 5'd17, r, d, l, s);
    checks++; if (r !== 32'hFFFFFFFF) $display("FAIL eo_mulh_res got %h exp ffffffff", r); else passed++;
    checks++; if (l !== mlat(2)) $display("FAIL eo_mulh_lat got %0d exp %0d", l, mlat(2)); else passed++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_early_out();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the execute-stage ALU.
- Captures operands when an M-extension op enters execute and runs shift-add multiply or restoring divide, one bit per cycle.
- Holds the fetch, decode and execute stages via stall_o until the result is ready, then presents the result for the execute/memory pipeline register.
- The hazard unit drives flush_e to abort a stale op.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- CNT_WIDTH, 6, iteration counter width (must satisfy 2^CNT_WIDTH > DATA_WIDTH).

Ports:
- clk  input  1  clock; rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_e  input  1  M-extension op valid in execute (forwarded operands final).
- funct3_e  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src_a_e  input  DATA_WIDTH  rs1 value after the forwarding mux.
- src_b_e  input  DATA_WIDTH  rs2 value after the forwarding mux.
- rd_e  input  5  destination register.
- flush_e  input  1  kill the op in execute.
- stall_o  output  1  hold IF/ID/EX stages.
- done_o  output  1  result valid, one-cycle pulse.
- result_o  output  DATA_WIDTH  final result; stable while done_o=1.
- rd_o  output  5  captured rd.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - stall_o=0, done_o=0, result_o=0, rd_o=0, counter=0, internal accumulators=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - stall_o = start_e & ~flush_e (combinational), so the op holds in execute from its first cycle.
  - On an edge with start_e & ~flush_e:
    - Latch funct3, rd and operands.
    - Signed ops (MULH, DIV, REM; MULHSU for src_a only) take operand magnitudes and record result-sign flags.
    - counter = DATA_WIDTH.
    - Next state = MUL for funct3<4, otherwise DIV.
    - Exception: special-case divides go straight to DONE.
- MUL:
  - Per cycle: if multiplier LSB=1, add multiplicand to the upper half of the 2*DATA_WIDTH product.
  - Shift the product right one bit, then counter -= 1.
  - counter reaches 0 -> DONE.
  - stall_o=1.
- DIV:
  - Per cycle, restoring step: shift {rem,quot} left, trial-subtract the divisor.
  - Keep the difference and set the quotient bit if it is non-negative.
  - counter -= 1; counter reaches 0 -> DONE.
  - stall_o=1.
- DONE:
  - Apply sign correction (two's-complement negate).
  - MUL selects the low word; MULH/MULHSU/MULHU select the high word.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
  - REM sign follows the dividend.
  - result_o is registered on entry to DONE.
  - done_o=1 and stall_o=0 for exactly this cycle, so the pipeline advances with the result.
  - Next state = IDLE unconditionally. start_e during DONE is ignored; it is the same retiring instruction.
- Latency:
  - Start cycle = cycle 0; done_o=1 in cycle DATA_WIDTH+1 (33 at default).
  - Stall spans cycles 0..DATA_WIDTH.
- Special cases (fast path, IDLE->DONE, done_o in cycle 1):
  - Divide by zero: quotient=all ones, remainder=src_a.
  - Signed overflow (src_a=0x80000000, src_b=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- flush_e:
  - In MUL or DIV: next state = IDLE, no done_o; stall_o drops in the same cycle.
  - In DONE: done_o still pulses; the pipeline register discards it.
- Reset mid-operation: returns to IDLE immediately; no done_o.
- result_o holds its last value in IDLE.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - In MUL, when the remaining multiplier bits are all zero, the remaining right-shift is applied in one step (shift by counter) and the block jumps to DONE.
  - Latency becomes (index of highest set bit of |multiplier|)+2, minimum 1 iteration.
  - Multiplier 0 goes to DONE after one MUL cycle.
  - DIV timing is unchanged.
- Not defined: fixed DATA_WIDTH iterations for every non-special op.

Test Plan:
- MUL 7 x 6 (funct3=0) -> done_o at cycle 33, result_o=42, stall_o high cycles 0..32, rd_o=captured rd.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0x00000000; MULHU with the same operands -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with done_o in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Start DIV, assert flush_e at cycle 10 -> IDLE at cycle 11, no done_o. Start MUL, pull rst_n low at cycle 5 -> all outputs 0 asynchronously. A new start in the following IDLE completes normally.
- With MULDIV_EARLY_OUT_EN defined: MUL 3 x 5 -> done_o by cycle 4, result_o=15.
